// File: rtl/aoi_pkg.sv
// Shared definitions for the AND-OR-INVERT pipeline.
// Mode encodings and helpers that decode them.
package aoi_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_AOI = 2'b00,
    MODE_AO  = 2'b01,
    MODE_OAI = 2'b10,
    MODE_OA  = 2'b11
  } mode_e;

  // OR-first modes reduce groups with OR, then AND them.
  function automatic logic or_first(
    input logic [MODE_W-1:0] m
  );
    return (m == MODE_OAI) || (m == MODE_OA);
  endfunction

  function automatic logic inverted(
    input logic [MODE_W-1:0] m
  );
    return (m == MODE_AOI) || (m == MODE_OAI);
  endfunction

endpackage

// File: rtl/aoi_stage.sv
// Valid/ready register slice with full throughput.
// Loads when empty or when its content leaves this cycle.
module aoi_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  always_comb begin
    in_ready = !valid_q | out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage AND-OR-INVERT family pipeline with handshakes.
// Stage 1 reduces each group, stage 2 combines groups.
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int GROUPS = 2,
  parameter int TERMS  = 2,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GROUPS*TERMS*WIDTH-1:0] in_data,
  input  logic [MODE_W-1:0]         in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [MODE_W-1:0]         out_mode,
  output logic [CNT_W-1:0]          out_count
);

  localparam int GW  = GROUPS * WIDTH;
  localparam int S1W = MODE_W + GW;
  localparam int S2W = MODE_W + WIDTH;

  logic [GW-1:0]    grp;
  logic [S1W-1:0]   s1_data;
  logic             s1_valid;
  logic             s2_ready;
  logic [MODE_W-1:0] s1_mode;
  logic [GW-1:0]    s1_grp;
  logic [WIDTH-1:0] res;
  logic [S2W-1:0]   s2_data;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    grp = '0;
    for (int g = 0; g < GROUPS; g++) begin
      grp[g*WIDTH +: WIDTH] = {WIDTH{!or_first(in_mode)}};
      for (int t = 0; t < TERMS; t++) begin
        if (or_first(in_mode))
          grp[g*WIDTH +: WIDTH] = grp[g*WIDTH +: WIDTH]
            | in_data[(g*TERMS+t)*WIDTH +: WIDTH];
        else
          grp[g*WIDTH +: WIDTH] = grp[g*WIDTH +: WIDTH]
            & in_data[(g*TERMS+t)*WIDTH +: WIDTH];
      end
    end
  end

  aoi_stage #(.DW(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_mode, grp}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_mode = s1_data[S1W-1 -: MODE_W];
  assign s1_grp  = s1_data[GW-1:0];

  always_comb begin
    res = {WIDTH{or_first(s1_mode)}};
    for (int g = 0; g < GROUPS; g++) begin
      if (or_first(s1_mode))
        res = res & s1_grp[g*WIDTH +: WIDTH];
      else
        res = res | s1_grp[g*WIDTH +: WIDTH];
    end
    if (inverted(s1_mode)) res = ~res;
  end

  aoi_stage #(.DW(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({s1_mode, res}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_mode = s2_data[S2W-1 -: MODE_W];
  assign out_data = s2_data[WIDTH-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_aoi_pipe.sv
// Bench for aoi_pipe: small default instance plus a wide one.
// Results are checked against a counting-based reference model.
module tb_aoi_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_in_data;
  logic [1:0]  a_in_mode, a_out_mode;
  logic [0:0]  a_out_data;
  logic [15:0] a_out_count;

  logic        rst_c;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [95:0] c_in_data;
  logic [1:0]  c_in_mode, c_out_mode;
  logic [7:0]  c_out_data;
  logic [3:0]  c_out_count;

  aoi_pipe dut_a (
    .clk(clk), .rst(rst_a),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode),
    .out_count(a_out_count)
  );

  aoi_pipe #(.GROUPS(3), .TERMS(4), .WIDTH(8), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst_c),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_mode(c_out_mode),
    .out_count(c_out_count)
  );

  logic [2:0]  q_a[$];
  logic [9:0]  q_c[$];
  logic [15:0] cnt_a = '0;
  logic [3:0]  cnt_c = '0;
  int          acc_a = 0;
  int          xfer_c = 0;

  // AOI: no group fully set -> 1; OAI: not every group has a set term -> 1.
  function automatic logic [7:0] model(input logic [95:0] d,
    input int gn, input int tn, input int w, input logic [1:0] m);
    logic [7:0] r = '0;
    for (int b = 0; b < w; b++) begin
      int full = 0;
      int any  = 0;
      for (int g = 0; g < gn; g++) begin
        int ones = 0;
        for (int t = 0; t < tn; t++) ones += int'(d[(g*tn+t)*w+b]);
        if (ones == tn) full++;
        if (ones > 0) any++;
      end
      if (m == 2'b00) r[b] = (full == 0);
      else if (m == 2'b01) r[b] = (full > 0);
      else if (m == 2'b10) r[b] = (any != gn);
      else r[b] = (any == gn);
    end
    return r;
  endfunction

  function automatic logic [95:0] rnd96();
    logic [95:0] d = {$urandom, $urandom, $urandom};
    if ($urandom_range(1, 0) == 1) d = d | {$urandom, $urandom, $urandom};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_a();
    logic [7:0] r;
    logic [2:0] e;
    @(negedge clk);
    if (rst_a) begin
      q_a.delete();
      cnt_a = '0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        checks++;
        assert (q_a.size() != 0) else begin
          failures++;
          $error("FAIL a_spurious observed=%0h expected=none", a_out_data);
        end
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          chk("a_out", {a_out_mode, a_out_data}, e);
        end
        cnt_a++;
      end
      if (a_in_valid && a_in_ready) begin
        r = model({92'b0, a_in_data}, 2, 2, 1, a_in_mode);
        q_a.push_back({a_in_mode, r[0]});
        acc_a++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_c();
    logic [9:0] e;
    @(negedge clk);
    if (rst_c) begin
      q_c.delete();
      cnt_c = '0;
    end else begin
      if (c_out_valid && c_out_ready) begin
        checks++;
        assert (q_c.size() != 0) else begin
          failures++;
          $error("FAIL c_spurious observed=%0h expected=none", c_out_data);
        end
        if (q_c.size() != 0) begin
          e = q_c.pop_front();
          chk("c_out", {c_out_mode, c_out_data}, e);
        end
        cnt_c++;
        xfer_c++;
      end
      if (c_in_valid && c_in_ready)
        q_c.push_back({c_in_mode, model(c_in_data, 3, 4, 8, c_in_mode)});
    end
    @(posedge clk); #1;
  endtask

  logic [2:0] hold;
  int guard;

  initial begin
    rst_a = 1'b1; rst_c = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_in_mode = '0; c_out_ready = 0;
    tick_a(); tick_a();
    rst_a = 1'b0; rst_c = 1'b0;

    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_count", a_out_count, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_mode", a_out_mode, 0);
    chk("rst_in_ready", a_in_ready, 1);

    a_out_ready = 1; a_in_valid = 1;
    a_in_data = 4'b0011; a_in_mode = 2'b00;
    tick_a();
    chk("lat_not_yet", a_out_valid, 0);
    a_in_data = 4'b0000;
    tick_a();
    chk("lat_valid", a_out_valid, 1);
    chk("aoi_0011", a_out_data, 0);
    a_in_valid = 0;
    tick_a();
    chk("aoi_0000", a_out_data, 1);
    tick_a();
    chk("lat_empty", a_out_valid, 0);

    rst_a = 1; tick_a(); rst_a = 0;
    a_in_valid = 1;
    for (int m = 0; m < 4; m++)
      for (int d = 0; d < 16; d++) begin
        a_in_mode = 2'(m);
        a_in_data = 4'(d);
        tick_a();
      end
    a_in_valid = 0;
    repeat (4) tick_a();
    chk("sweep_drained", q_a.size(), 0);
    chk("sweep_count", a_out_count, 64);
    chk("sweep_count_model", a_out_count, cnt_a);

    a_out_ready = 0; a_in_valid = 1; acc_a = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_data = 4'($urandom);
      a_in_mode = 2'($urandom);
      tick_a();
      if (i == 1) begin
        chk("bp_out_valid", a_out_valid, 1);
        hold = {a_out_mode, a_out_data};
      end
      if (i >= 2) chk("bp_stable", {a_out_mode, a_out_data}, hold);
    end
    chk("bp_accepted", acc_a, 2);
    chk("bp_in_ready", a_in_ready, 0);
    a_in_valid = 0; a_out_ready = 1;
    repeat (4) tick_a();
    chk("bp_drained", q_a.size(), 0);

    a_out_ready = 0; a_in_valid = 1;
    repeat (2) tick_a();
    a_in_valid = 0;
    rst_a = 1; tick_a(); rst_a = 0;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_count", a_out_count, 0);
    chk("mid_rst_ready", a_in_ready, 1);
    a_out_ready = 1;
    repeat (3) tick_a();
    chk("mid_rst_no_out", a_out_valid, 0);

    c_out_ready = 1; c_in_valid = 1; guard = 0;
    while (xfer_c < 17 && guard < 60) begin
      c_in_data = rnd96();
      c_in_mode = 2'($urandom);
      tick_c();
      guard++;
    end
    chk("c_xfer17", xfer_c, 17);
    chk("c_wrap", c_out_count, 1);

    for (int i = 0; i < 400; i++) begin
      c_in_valid  = ($urandom_range(3, 0) != 0);
      c_out_ready = ($urandom_range(2, 0) != 0);
      c_in_data   = rnd96();
      c_in_mode   = 2'($urandom);
      tick_c();
    end
    c_in_valid = 0; c_out_ready = 1;
    repeat (4) tick_c();
    chk("c_drained", q_c.size(), 0);
    chk("c_count", c_out_count, cnt_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
